// File: rtl/modn_counter_pkg.sv
// modn_counter_pkg: direction and end-mode encodings shared by the modulo-N counter
package modn_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        END_WRAP = 1'b0,
        END_SAT  = 1'b1
    } end_e;

endpackage

// File: rtl/modn_prescaler.sv
// modn_prescaler: tick generator, one tick every presc+1 enabled cycles
//   clk, rst  : clock, async active-high reset
//   en        : advance enable (already gated by the halt flag)
//   clr       : synchronous clear of the phase counter (load)
//   presc     : tick period minus one
//   tick      : combinational, high in the cycle the period completes
module modn_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] presc,
    output logic             tick
);

    logic [PRE_W-1:0] p_q, p_d;

    // >= rather than == so that lowering presc below p ticks on the next enabled cycle
    always_comb begin
        tick = en && (p_q >= presc);
        p_d  = clr ? '0 : tick ? '0 : en ? p_q + 1'b1 : p_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_q <= '0;
        else     p_q <= p_d;
    end

endmodule

// File: rtl/modn_counter.sv
// modn_counter: prescaled up/down modulo-N counter with wrap/saturate and one-shot halt
//   clk, rst  : clock, async active-high reset
//   en        : advance enable for prescaler and counter
//   up        : 1 = count up, 0 = count down
//   sat       : 1 = saturate at end value, 0 = wrap
//   oneshot   : 1 = halt after the first wrap until the next load
//   load      : synchronous load, overrides everything but reset
//   load_val  : load value, clamped to MODULUS-1
//   presc     : tick period minus one, in enabled cycles
//   count     : registered count
//   wrap      : registered one-cycle pulse after each wrap
//   at_end    : count equals the end value for the current direction
//   halted    : one-shot halt active
module modn_counter
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 6,
    parameter int PRE_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] presc,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_end,
    output logic             halted
);

    localparam int              LAST_I = MODULUS - 1;
    localparam logic [WIDTH-1:0] LAST  = LAST_I[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             halted_q, halted_d;
    logic             tick;
    logic             is_up;
    logic             wrap_evt;

    modn_prescaler #(.PRE_W(PRE_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (en && !halted_q),
        .clr   (load),
        .presc (presc),
        .tick  (tick)
    );

    always_comb begin
        is_up    = (up == DIR_UP);
        at_end   = is_up ? (count_q == LAST) : (count_q == '0);
        wrap_evt = tick && at_end && (sat == END_WRAP);
        count_d  = load     ? ((load_val > LAST) ? LAST : load_val) :
                   !tick    ? count_q :
                   wrap_evt ? (is_up ? '0 : LAST) :
                   at_end   ? count_q :
                   is_up    ? count_q + 1'b1 : count_q - 1'b1;
        wrap_d   = !load && wrap_evt;
        halted_d = !load && (halted_q || (wrap_evt && oneshot));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            halted_q <= halted_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_modn_counter.sv
// tb_modn_counter: directed scenarios and random stimulus against a behavioural model
module tb_modn_counter;

    localparam int MOD = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, sat = 1'b0, oneshot = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [7:0] presc = '0;
    logic [3:0] count;
    logic       wrap, at_end, halted;

    int n_chk = 0;
    int n_fail = 0;
    int m_cnt = 0, m_p = 0, m_halt = 0, m_wrap = 0;

    modn_counter dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .oneshot(oneshot),
        .load(load), .load_val(load_val), .presc(presc),
        .count(count), .wrap(wrap), .at_end(at_end), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_p = 0; m_halt = 0; m_wrap = 0;
    endtask

    // Behavioural model applied at each rising edge with the inputs present at that edge
    task automatic model_step();
        int end_v;
        m_wrap = 0;
        if (load) begin
            m_cnt = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
            m_p = 0;
            m_halt = 0;
        end else if (en && !m_halt) begin
            if (m_p >= int'(presc)) begin
                m_p = 0;
                end_v = up ? MOD - 1 : 0;
                if (m_cnt != end_v) m_cnt = up ? m_cnt + 1 : m_cnt - 1;
                else if (!sat) begin
                    m_cnt = up ? 0 : MOD - 1;
                    m_wrap = 1;
                    if (oneshot) m_halt = 1;
                end
            end else m_p++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), m_cnt);
        check({tag, ".wrap"}, int'(wrap), m_wrap);
        check({tag, ".halted"}, int'(halted), m_halt);
        check({tag, ".at_end"}, int'(at_end), int'(m_cnt == (up ? MOD - 1 : 0)));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_wrap[7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        #12;
        check("reset.count", int'(count), 0);
        check("reset.wrap", int'(wrap), 0);
        check("reset.halted", int'(halted), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Basic wrapping count with presc=0
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step("basic");
            check("basic.seq", int'(count), exp_seq[i]);
            check("basic.wrap_seq", int'(wrap), exp_wrap[i]);
        end

        // Count down every third enabled cycle, then freeze with en low
        load = 1'b1; load_val = 4'd0; step("down_load");
        load = 1'b0; presc = 8'd2; up = 1'b0;
        for (int i = 0; i < 7; i++) step("down");
        en = 1'b0;
        for (int i = 0; i < 4; i++) step("frozen");
        en = 1'b1;
        for (int i = 0; i < 6; i++) step("down2");

        // Saturation at 5, then direction reversal
        presc = 8'd0; up = 1'b1; sat = 1'b1;
        load = 1'b1; load_val = 4'd5; step("sat_load");
        load = 1'b0;
        for (int i = 0; i < 4; i++) step("sat");
        check("sat.hold", int'(count), 5);
        up = 1'b0; step("sat_rev");
        check("sat.rev", int'(count), 4);

        // One-shot halt and release by load
        sat = 1'b0; up = 1'b1; oneshot = 1'b1;
        load = 1'b1; load_val = 4'd4; step("os_load");
        load = 1'b0;
        for (int i = 0; i < 12; i++) step("oneshot");
        check("oneshot.halted", int'(halted), 1);
        check("oneshot.count", int'(count), 0);
        load = 1'b1; load_val = 4'd3; step("os_release");
        check("os_release.count", int'(count), 3);
        load = 1'b0; oneshot = 1'b0;

        // Load of an out-of-range value coincident with a tick
        load_val = 4'd9; load = 1'b1; step("clamp");
        check("clamp.count", int'(count), 5);
        load = 1'b0;

        // Async reset between edges mid-count
        presc = 8'd2; load = 1'b1; load_val = 4'd2; step("pre_rst");
        load = 1'b0; up = 1'b1;
        for (int i = 0; i < 4; i++) step("pre_rst_run");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst.count", int'(count), 0);
        check("async_rst.wrap", int'(wrap), 0);
        check("async_rst.halted", int'(halted), 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) step("post_rst");

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) sat = ~sat;
            if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
            if ($urandom_range(0, 9) == 0) presc = 8'($urandom_range(0, 3));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/modn_counter.md
MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 Parameter WIDTH, default 4, count register width in bits.
REQ-002 Parameter MODULUS, default 6, count range 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 Parameter PRE_W, default 8, prescaler width in bits.
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  advance enable for prescaler and counter.
REQ-007 up  in  1  direction: 1 = up, 0 = down.
REQ-008 sat  in  1  end mode: 1 = saturate at end value, 0 = wrap.
REQ-009 oneshot  in  1  1 = halt after first wrap until next load.
REQ-010 load  in  1  synchronous load strobe.
REQ-011 load_val  in  WIDTH  value for load.
REQ-012 presc  in  PRE_W  tick period minus one, in enabled cycles.
REQ-013 count  out  WIDTH  current count, registered.
REQ-014 wrap  out  1  one-cycle pulse, registered, on every wrap event.
REQ-015 at_end  out  1  level: count equals end value for current direction.
REQ-016 halted  out  1  level: oneshot halt active.

Function
REQ-017 The prescaler counter p SHALL increment on each cycle with en=1 and halted=0, hold otherwise.
REQ-018 A tick SHALL occur in a cycle where en=1, halted=0 and p >= presc; p SHALL clear to 0 in that cycle.
REQ-019 With presc=0 a tick SHALL occur every enabled cycle; a presc lowered below p SHALL give a tick on the next enabled cycle.
REQ-020 End value SHALL be MODULUS-1 when up=1, 0 when up=0; at_end SHALL be combinational from count and up.
REQ-021 On tick, not at end: count SHALL step by +1 (up) or -1 (down) at the same edge.
REQ-022 On tick at end with sat=0: count SHALL go to 0 (up) or MODULUS-1 (down) and wrap SHALL be 1 for exactly the following cycle.
REQ-023 On tick at end with sat=1: count SHALL hold and wrap SHALL stay 0.
REQ-024 On a wrap event with oneshot=1, halted SHALL set at the same edge; while halted, p and count SHALL hold.
REQ-025 load=1 SHALL take priority over any tick: count <= min(load_val, MODULUS-1), p <= 0, halted <= 0, wrap <= 0, regardless of en.
REQ-026 A direction change SHALL take effect on the next tick without disturbing count or p.
REQ-027 All count arithmetic SHALL be WIDTH bits and never produce a value >= MODULUS.

Reset
REQ-028 rst=1 SHALL immediately force count=0, p=0, wrap=0, halted=0, independent of clk.
REQ-029 Reset deassertion SHALL be synchronised externally; the first tick SHALL occur no earlier than presc+1 enabled cycles after release.
REQ-030 Reset asserted mid-operation SHALL discard pending tick, load and halt state.

Structure
REQ-031 Package modn_counter_pkg SHALL hold the direction and end-mode encodings (DIR_UP/DIR_DOWN, END_WRAP/END_SAT).
REQ-032 The prescaler SHALL be a sub-module named modn_prescaler (inputs en, clr, presc; output tick).
REQ-033 Counter, halt flag and wrap register SHALL reside in modn_counter.

Verification
REQ-034 Defaults, presc=0, up=1, sat=0, en=1 from reset -> count 0,1,2,3,4,5,0; wrap=1 only in cycle after 5->0.
REQ-035 presc=2, up=0 from count=0 -> count changes every 3rd enabled cycle: 0,5,4,...; en low for 4 cycles freezes count and p.
REQ-036 sat=1, up=1 at count=5 -> count stays 5, wrap never 1, at_end=1; up=0 -> next tick count=4.
REQ-037 oneshot=1 from count=4 -> 5, 0 with wrap=1, halted=1, count held at 0 for 10 cycles; load with load_val=3 -> count=3, halted=0.
REQ-038 load with load_val=9 coincident with tick -> count=5, p=0, wrap=0.
REQ-039 rst pulse mid-count (count=3, p=1), asserted between clock edges -> count=0, halted=0, wrap=0 before next edge.
